mem_port_arbiter: RTL and testbench

Sequences the single-ported main memory and shares it between the instruction-fetch requester and the load/store data requester of the multicycle CPU. It replaces the fixed wait-state counting in the control unit with a req/done handshake. It latches the winning request, drives the memory for the configured read latency or a one-cycle write, captures read data, and pulses a per-port completion strobe. It sits between the control unit/datapath and the memory model.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between instruction fetch and load/store ports.
// Optional MEM_ARB_RR_EN: round-robin on simultaneous requests (default: data over fetch).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_done,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_owner
);

  localparam int unsigned     CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic              r_we, w_we;
  logic              r_owner, w_owner;
  logic              r_if_done, w_if_done;
  logic              r_d_done, w_d_done;
  logic              r_mem_wr, w_mem_wr;
  logic              r_busy, w_busy;
  logic              w_grant_d;
`ifdef MEM_ARB_RR_EN
  logic              r_last_d, w_last_d;
`endif

  // Arbitration: which port wins when the arbiter is idle.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    w_grant_d = i_d_req && (!i_if_req || !r_last_d);
`else
    w_grant_d = i_d_req;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_we      = r_we;
    w_owner   = r_owner;
    w_rdata   = r_rdata;
    w_if_done = 1'b0;
    w_d_done  = 1'b0;
    w_mem_wr  = 1'b0;
`ifdef MEM_ARB_RR_EN
    w_last_d  = r_last_d;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_if_req || i_d_req) begin
          w_state = ST_ACCESS;
          w_cnt   = CNT_INIT;
          w_owner = w_grant_d;
`ifdef MEM_ARB_RR_EN
          w_last_d = w_grant_d;
`endif
          if (w_grant_d) begin
            w_addr   = i_d_addr;
            w_wdata  = i_d_wdata;
            w_we     = i_d_we;
            w_mem_wr = i_d_we;
          end else begin
            w_addr = i_if_addr;
            w_we   = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (r_we || (r_cnt == '0)) begin
          if (!r_we) begin
            w_rdata = i_mem_rdata;
          end
          w_state   = ST_DONE;
          w_if_done = !r_owner;
          w_d_done  = r_owner;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_owner   <= 1'b0;
      r_rdata   <= '0;
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_busy    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_d  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_we      <= w_we;
      r_owner   <= w_owner;
      r_rdata   <= w_rdata;
      r_if_done <= w_if_done;
      r_d_done  <= w_d_done;
      r_mem_wr  <= w_mem_wr;
      r_busy    <= w_busy;
`ifdef MEM_ARB_RR_EN
      r_last_d  <= w_last_d;
`endif
    end
  end

  assign o_if_done   = r_if_done;
  assign o_d_done    = r_d_done;
  assign o_rdata     = r_rdata;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wr    = r_mem_wr;
  assign o_busy      = r_busy;
  assign o_owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-timing reference model.
// Second instance (READ_LAT=1) checks back-to-back read spacing.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned READ_LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, mem_rdata;
  logic              o_if_done, o_d_done, o_mem_wr, o_busy, o_owner;
  logic [DATA_W-1:0] o_rdata, o_mem_wdata;
  logic [ADDR_W-1:0] o_mem_addr;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_done(o_if_done),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .o_d_done(o_d_done),
    .o_rdata(o_rdata), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wr(o_mem_wr),
    .i_mem_rdata(mem_rdata), .o_busy(o_busy), .o_owner(o_owner)
  );

  logic              if1_req;
  logic [ADDR_W-1:0] if1_addr;
  logic              o1_if_done, o1_d_done, o1_mem_wr, o1_busy, o1_owner;
  logic [DATA_W-1:0] o1_rdata, o1_mem_wdata, mem1_rdata;
  logic [ADDR_W-1:0] o1_mem_addr;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(if1_req), .i_if_addr(if1_addr), .o_if_done(o1_if_done),
    .i_d_req(1'b0), .i_d_we(1'b0), .i_d_addr('0), .i_d_wdata('0), .o_d_done(o1_d_done),
    .o_rdata(o1_rdata), .o_mem_addr(o1_mem_addr), .o_mem_wdata(o1_mem_wdata), .o_mem_wr(o1_mem_wr),
    .i_mem_rdata(mem1_rdata), .o_busy(o1_busy), .o_owner(o1_owner)
  );

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return 32'h8C020004 + 32'(i) * 32'h01000101;
  endfunction

  // Memory: data is only valid once a read address has been held READ_LAT cycles.
  logic [DATA_W-1:0] mem_arr [16];
  logic              v0;
  int                rd_age;
  assign v0 = o_busy & ~o_mem_wr & ~o_if_done & ~o_d_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= init_val(i);
    end else if (o_mem_wr) begin
      mem_arr[o_mem_addr[5:2]] <= o_mem_wdata;
    end
  end
  always @(posedge clk) rd_age <= v0 ? rd_age + 1 : 0;
  assign mem_rdata  = (v0 && rd_age >= int'(READ_LAT) - 1) ? mem_arr[o_mem_addr[5:2]] : 32'hBAD0BAD0;
  assign mem1_rdata = (o1_busy && !o1_if_done) ? (o1_mem_addr ^ 32'h5EED0000) : 32'hBAD0BAD0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one outstanding transaction described by its grant cycle.
  bit                m_active, m_port, m_we, m_last_d, e_owner, allow_new;
  int                m_start, m_len, n_if, n_d, scen;
  logic [ADDR_W-1:0] m_addr, e_addr;
  logic [DATA_W-1:0] m_wdata, e_rdata;
  logic [DATA_W-1:0] ref_mem [16];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    return 32'h100 + 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_last_d = 1'b0; e_owner = 1'b0;
    m_start = -100; m_len = 0; n_if = 0; n_d = 0;
    m_addr = '0; e_addr = '0; m_wdata = '0; e_rdata = '0;
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic model_grant();
    bit gd;
    if (!m_active && rst_n && (if_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
      gd = d_req && (!if_req || !m_last_d);
      m_last_d = gd;
`else
      gd = d_req;
`endif
      m_active = 1'b1;
      m_start  = cyc;
      m_port   = gd;
      m_we     = gd ? d_we : 1'b0;
      m_addr   = gd ? d_addr : if_addr;
      if (gd) m_wdata = d_wdata;
      m_len    = m_we ? 1 : int'(READ_LAT);
      e_owner  = gd;
      e_addr   = m_addr;
    end
  endtask

  task automatic start_scenario();
    int p;
    p = (scen < 3) ? scen : int'($urandom_range(0, 3));
    if (scen == 0) if_addr = 32'h40;
    if (scen == 1) begin d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_we = 1'b1; end
    case (p)
      0: n_if = int'($urandom_range(1, 2));
      1: n_d  = int'($urandom_range(1, 2));
      default: begin n_if = int'($urandom_range(1, 3)); n_d = int'($urandom_range(1, 3)); end
    endcase
    if (scen < 2) begin n_if = (p == 0) ? 1 : 0; n_d = (p == 1) ? 1 : 0; end
    if (scen == 2) begin n_if = 2; n_d = 2; end
    if_req = (n_if != 0);
    d_req  = (n_d != 0);
    scen++;
  endtask

  // One clock: check this cycle's outputs, then drive requesters and update the model.
  task automatic step();
    int k;
    bit acc, dn;
    @(negedge clk);
    cyc++;
    k   = cyc - m_start;
    acc = m_active && k >= 1 && k <= m_len;
    dn  = m_active && k == m_len + 1;
    if (dn && !m_we) e_rdata = ref_mem[m_addr[5:2]];
    chk("busy",      32'(o_busy),    32'(acc || dn));
    chk("mem_wr",    32'(o_mem_wr),  32'(acc && m_we));
    chk("if_done",   32'(o_if_done), 32'(dn && !m_port));
    chk("d_done",    32'(o_d_done),  32'(dn && m_port));
    chk("owner",     32'(o_owner),   32'(e_owner));
    chk("mem_addr",  o_mem_addr,     e_addr);
    chk("mem_wdata", o_mem_wdata,    m_wdata);
    chk("rdata",     o_rdata,        e_rdata);
    if (dn) begin
      m_active = 1'b0;
      if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
      if (m_port) begin n_d--;  if (n_d == 0)  d_req  = 1'b0; end
      else        begin n_if--; if (n_if == 0) if_req = 1'b0; end
    end
    if (!if_req || (m_active && !m_port)) if_addr = rand_addr();
    if (!d_req || (m_active && m_port)) begin
      d_addr  = rand_addr();
      d_wdata = $urandom;
      d_we    = 1'($urandom_range(0, 1));
    end
    if (allow_new && !m_active && n_if == 0 && n_d == 0 && $urandom_range(0, 3) != 0) start_scenario();
    if (!dn) model_grant();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_active || n_if != 0 || n_d != 0) && guard < 200) begin
      step();
      guard++;
    end
    chk("drain_timeout", 32'(guard < 200), 32'd1);
    step();
  endtask

  logic [6:0] l1_busy, l1_done;

  initial begin
    rst_n = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    if1_req = 1'b0; if1_addr = '0;
    scen = 0;
    allow_new = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    allow_new = 1'b1;
    repeat (900) step();
    allow_new = 1'b0;
    drain();

    // Reset pulse during the second ACCESS cycle of a fetch.
    if_addr = 32'h124; if_req = 1'b1; n_if = 1;
    model_grant();
    step();
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy",     32'(o_busy),    32'd0);
    chk("rst_mem_wr",   32'(o_mem_wr),  32'd0);
    chk("rst_if_done",  32'(o_if_done), 32'd0);
    chk("rst_d_done",   32'(o_d_done),  32'd0);
    chk("rst_owner",    32'(o_owner),   32'd0);
    chk("rst_mem_addr", o_mem_addr,     32'd0);
    chk("rst_rdata",    o_rdata,        32'd0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    if_addr = 32'h44; if_req = 1'b1; n_if = 1;
    model_grant();
    repeat (int'(READ_LAT) + 2) step();
    if_req = 1'b1; d_req = 1'b1; n_if = 2; n_d = 2;
    model_grant();
    drain();

    // READ_LAT=1 instance: two consecutive fetches with the request held.
    l1_busy = 7'b0110110;
    l1_done = 7'b0100100;
    if1_addr = 32'h200; if1_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("l1_busy",    32'(o1_busy),    32'(l1_busy[k]));
      chk("l1_if_done", 32'(o1_if_done), 32'(l1_done[k]));
      chk("l1_d_done",  32'(o1_d_done),  32'd0);
      chk("l1_mem_wr",  32'(o1_mem_wr),  32'd0);
      chk("l1_owner",   32'(o1_owner),   32'd0);
      chk("l1_wdata",   o1_mem_wdata,    32'd0);
      if (k == 2) begin
        chk("l1_rdata0", o1_rdata, 32'h200 ^ 32'h5EED0000);
        if1_addr = 32'h204;
      end
      if (k == 5) begin
        chk("l1_rdata1", o1_rdata, 32'h204 ^ 32'h5EED0000);
        if1_req = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
